// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch and decode/control stages.
package riscv_pkg;

  // Fetch stage control states
  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalt
  } fetch_state_e;

  // An all-zero word terminates a program
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  localparam int unsigned IMEM_DEPTH = 32;

  // Major opcodes, consumed by decode/control
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BEQ   = 7'b1100011;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO of {index, instruction}. Entry 0 is always the head.
module fetch_queue #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [ADDR_W-1:0]  push_linha,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic               head_valid,
  output logic [ADDR_W-1:0]  head_linha,
  output logic [INSTR_W-1:0] head_instr
);

  logic [ADDR_W-1:0]  linha_q [2];
  logic [ADDR_W-1:0]  linha_d [2];
  logic [INSTR_W-1:0] instr_q [2];
  logic [INSTR_W-1:0] instr_d [2];
  logic [1:0]         count_q, count_d;

  // Next-state: flush wins; push/pop shift entries toward the head
  always_comb begin
    linha_d = linha_q;
    instr_d = instr_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          linha_d[count_q[0]] = push_linha;
          instr_d[count_q[0]] = push_instr;
          count_d             = count_q + 2'd1;
        end
        2'b01: begin
          linha_d[0] = linha_q[1];
          instr_d[0] = instr_q[1];
          count_d    = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            linha_d[0] = push_linha;
            instr_d[0] = push_instr;
          end else begin
            linha_d[0] = linha_q[1];
            instr_d[0] = instr_q[1];
            linha_d[1] = push_linha;
            instr_d[1] = push_instr;
          end
        end
        default: ;
      endcase
    end
  end

  // Queue storage and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      linha_q <= '{default: '0};
      instr_q <= '{default: '0};
      count_q <= 2'd0;
    end else begin
      linha_q <= linha_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  // Head outputs read as zero while empty
  always_comb begin
    count      = count_q;
    head_valid = (count_q != 2'd0);
    head_linha = head_valid ? linha_q[0] : '0;
    head_instr = head_valid ? instr_q[0] : '0;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: program-loadable imem, fetch PC, and a 2-entry prefetch queue with
// branch-redirect flush.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH  = riscv_pkg::IMEM_DEPTH,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [INSTR_W-1:0]            load_data,
  input  logic                          start,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_target,
  input  logic                          instr_ready,
  output logic                          instr_valid,
  output logic [INSTR_W-1:0]            instrucao,
  output logic [ADDR_W-1:0]             instr_linha,
  output logic                          busy,
  output logic                          halted
);
  import riscv_pkg::*;

  localparam int unsigned IdxW = $clog2(IMEM_DEPTH);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [INSTR_W-1:0] word;
  logic [1:0]         queue_count;
  logic               push, pop, flush, space;

  // Program load, only while idle
  always_ff @(posedge clock) begin
    if (load_en && (state_q == StIdle)) begin
      imem[load_addr] <= load_data;
    end
  end

  // Next-state, PC and queue control; redirect overrides everything else
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    pop     = instr_valid && instr_ready;
    space   = (32'(queue_count) < QUEUE_DEPTH) || pop;
    word    = imem[pc_q[IdxW-1:0]];
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      StFetch: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = redirect_target;
          state_d = (32'(redirect_target) >= IMEM_DEPTH) ? StHalt : StFetch;
        end else if (space) begin
          if (word == HALT_WORD) begin
            state_d = StHalt;
          end else begin
            push = 1'b1;
            pc_d = pc_q + ADDR_W'(1);
            // Last imem entry: stop rather than wrap
            if (pc_q == ADDR_W'(IMEM_DEPTH - 1)) state_d = StHalt;
          end
        end
      end
      StHalt: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = redirect_target;
          state_d = (32'(redirect_target) >= IMEM_DEPTH) ? StHalt : StFetch;
        end else if (start && (queue_count == 2'd0)) begin
          state_d = StFetch;
          pc_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and PC registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_linha (pc_q),
    .push_instr (word),
    .pop        (pop && !flush),
    .flush      (flush),
    .count      (queue_count),
    .head_valid (instr_valid),
    .head_linha (instr_linha),
    .head_instr (instrucao)
  );

  // Status outputs
  always_comb begin
    busy   = (state_q == StFetch);
    halted = (state_q == StHalt) && (queue_count == 2'd0);
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: program load, back-pressure, redirect,
// out-of-range redirect, end-of-imem halt, load-during-fetch and async reset.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        redirect_valid;
  logic [11:0] redirect_target;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instrucao;
  logic [11:0] instr_linha;
  logic        busy;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_mem [32];

  always #5 clock = ~clock;

  instr_fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .load_en         (load_en),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .start           (start),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_ready     (instr_ready),
    .instr_valid     (instr_valid),
    .instrucao       (instrucao),
    .instr_linha     (instr_linha),
    .busy            (busy),
    .halted          (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic load_word(input int addr, input logic [31:0] data);
    @(negedge clock);
    load_en   = 1'b1;
    load_addr = 5'(addr);
    load_data = data;
    exp_mem[addr] = data;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // Pulse start for one edge; returns at the following negedge
  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Drain with ready high; expect indices first..first+n-1 then halted
  task automatic drain_expect(input string tag, input int first, input int n);
    int k = 0;
    instr_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc != 0) @(negedge clock);
      if (instr_valid) begin
        if (k < n) begin
          check_eq($sformatf("%s linha[%0d]", tag, k), 32'(instr_linha), 32'(first + k));
          check_eq($sformatf("%s instr[%0d]", tag, k), instrucao, exp_mem[first + k]);
        end
        k++;
      end
      if (halted) break;
    end
    check_eq({tag, " count"}, 32'(k), 32'(n));
    check_eq({tag, " halted"}, 32'(halted), 32'd1);
    check_eq({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; redirect_valid = 1'b0; redirect_target = '0; instr_ready = 1'b0;

    // Reset values
    #2;
    check_eq("rst valid", 32'(instr_valid), 32'd0);
    check_eq("rst instr", instrucao, 32'd0);
    check_eq("rst linha", 32'(instr_linha), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst halted", 32'(halted), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Basic program ending in a halt word
    load_word(0, 32'h00A0_0093);
    load_word(1, 32'h0020_F133);
    load_word(2, 32'h0000_0000);
    pulse_start();
    check_eq("t1 busy", 32'(busy), 32'd1);
    check_eq("t1 empty after start", 32'(instr_valid), 32'd0);
    drain_expect("t1", 0, 2);

    // Back-pressure: queue fills to 2 and holds the head
    do_reset();
    for (int i = 0; i < 5; i++) load_word(i, 32'h0110_0000 + 32'(i));
    load_word(5, 32'h0000_0000);
    instr_ready = 1'b0;
    pulse_start();
    repeat (4) @(negedge clock);
    check_eq("t2 count", 32'(dut.queue_count), 32'd2);
    check_eq("t2 pc", 32'(dut.pc_q), 32'd2);
    check_eq("t2 head linha", 32'(instr_linha), 32'd0);
    check_eq("t2 head instr", instrucao, 32'h0110_0000);
    drain_expect("t2", 0, 5);

    // Redirect into a full queue
    do_reset();
    for (int i = 0; i < 8; i++) load_word(i, 32'h0220_0000 + 32'(i));
    load_word(8, 32'h0000_0000);
    instr_ready = 1'b0;
    pulse_start();
    redirect_valid = 1'b1; redirect_target = 12'd3;
    @(negedge clock);
    redirect_valid = 1'b0;
    check_eq("t3 flushed", 32'(instr_valid), 32'd0);
    repeat (3) @(negedge clock);
    check_eq("t3 full count", 32'(dut.queue_count), 32'd2);
    check_eq("t3 full head", 32'(instr_linha), 32'd3);
    redirect_valid = 1'b1; redirect_target = 12'd1; instr_ready = 1'b1;
    @(negedge clock);
    redirect_valid = 1'b0;
    check_eq("t3 gap valid", 32'(instr_valid), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      check_eq($sformatf("t3 valid[%0d]", i), 32'(instr_valid), 32'd1);
      check_eq($sformatf("t3 linha[%0d]", i), 32'(instr_linha), 32'(i));
      check_eq($sformatf("t3 instr[%0d]", i), instrucao, exp_mem[i]);
    end

    // Out-of-range redirect while fetching
    check_eq("t4 busy before", 32'(busy), 32'd1);
    redirect_valid = 1'b1; redirect_target = 12'd40;
    @(negedge clock);
    redirect_valid = 1'b0;
    check_eq("t4 halted", 32'(halted), 32'd1);
    check_eq("t4 valid", 32'(instr_valid), 32'd0);
    check_eq("t4 busy", 32'(busy), 32'd0);
    check_eq("t4 pc", 32'(dut.pc_q), 32'd40);

    // Full imem: 0..31 once, then halt without wrapping
    do_reset();
    for (int i = 0; i < 32; i++) load_word(i, 32'h1000_0000 + 32'(i));
    instr_ready = 1'b1;
    pulse_start();
    drain_expect("t5", 0, 32);
    check_eq("t5 pc no wrap", 32'(dut.pc_q), 32'd32);

    // Load during fetch is ignored; async reset mid-fetch
    do_reset();
    instr_ready = 1'b0;
    pulse_start();
    load_en = 1'b1; load_addr = 5'd0; load_data = 32'h0000_0000;
    @(negedge clock);
    load_en = 1'b0;
    check_eq("t6 busy", 32'(busy), 32'd1);
    check_eq("t6 valid", 32'(instr_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6 async valid", 32'(instr_valid), 32'd0);
    check_eq("t6 async busy", 32'(busy), 32'd0);
    check_eq("t6 async halted", 32'(halted), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    pulse_start();
    drain_expect("t6 rerun", 0, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
